// File: rtl/sqrt_pkg.sv
// Shared types for the square-root datapath.
// Widths, stage states and the {D, Q, R} result bundle.
package sqrt_pkg;

    localparam int SQRT_W_D = 32;
    localparam int SQRT_W_Q = SQRT_W_D / 2;
    localparam int SQRT_W_R = SQRT_W_Q + 1;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        CHECK,
        OUT
    } sqrt_stage_state_t;

    typedef struct packed {
        logic [SQRT_W_D-1:0] d;
        logic [SQRT_W_Q-1:0] q;
        logic [SQRT_W_R-1:0] r;
    } sqrt_result_t;

    // Round-to-nearest: (Q+0.5)^2 = Q^2 + Q + 0.25, so R > Q rounds up.
    function automatic logic [SQRT_W_Q:0] sqrt_round(
        input logic [SQRT_W_Q-1:0] q,
        input logic [SQRT_W_R-1:0] r
    );
        logic [SQRT_W_Q:0] q_ext;
        q_ext = {1'b0, q};
        return (r > q_ext) ? q_ext + 1'b1 : q_ext;
    endfunction

endpackage

// File: rtl/sqrt_result_stage_if.sv
// Handshake bundle between the sqrt block and the result stage.
// master drives requests and out_ready; slave is the stage.
interface sqrt_result_stage_if #(
    parameter int W_CNT = 16
);
    import sqrt_pkg::*;

    logic                in_valid;
    logic                in_ready;
    logic [SQRT_W_D-1:0] in_d;
    logic [SQRT_W_Q-1:0] in_q;
    logic [SQRT_W_R-1:0] in_r;

    logic                out_valid;
    logic                out_ready;
    logic [SQRT_W_Q:0]   out_q_round;
    logic [SQRT_W_Q-1:0] out_q;
    logic                out_err;
    logic [W_CNT-1:0]    res_count;
    logic [W_CNT-1:0]    err_count;

    modport master (
        output in_valid, in_d, in_q, in_r, out_ready,
        input  in_ready, out_valid, out_q_round, out_q,
        input  out_err, res_count, err_count
    );

    modport slave (
        input  in_valid, in_d, in_q, in_r, out_ready,
        output in_ready, out_valid, out_q_round, out_q,
        output out_err, res_count, err_count
    );

endinterface

// File: rtl/sqrt_shift_add_mul.sv
// Iterative shift-add multiplier, one multiplier bit per cycle.
// done is high during the final step; prod is complete after that edge.
module sqrt_shift_add_mul
    import sqrt_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [SQRT_W_Q-1:0]   a,
    input  logic [SQRT_W_Q-1:0]   b,
    output logic                  done,
    output logic [2*SQRT_W_Q-1:0] prod
);

    localparam int W_P   = 2 * SQRT_W_Q;
    localparam int CNT_W = $clog2(SQRT_W_Q);

    logic [SQRT_W_Q-1:0] a_q;
    logic [SQRT_W_Q-1:0] b_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                busy_q;
    logic [W_P-1:0]      acc_q;
    logic [W_P-1:0]      addend;

    assign addend = W_P'(b_q) << cnt_q;
    assign done   = busy_q && (cnt_q == CNT_W'(SQRT_W_Q - 1));
    assign prod   = acc_q;

    // Load operands on start, then add one shifted partial product per cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            acc_q  <= '0;
        end else if (start) begin
            a_q    <= a;
            b_q    <= b;
            cnt_q  <= '0;
            busy_q <= 1'b1;
            acc_q  <= '0;
        end else if (busy_q) begin
            if (a_q[cnt_q]) begin
                acc_q <= acc_q + addend;
            end
            cnt_q <= cnt_q + 1'b1;
            if (done) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/sqrt_result_stage.sv
// Checks a captured {D, Q, R} sqrt result, rounds Q, and returns it
// over valid/ready with running result and error counters.
module sqrt_result_stage
    import sqrt_pkg::*;
#(
    parameter int W_CNT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    sqrt_result_stage_if.slave io
);

    localparam int W_D = SQRT_W_D;
    localparam int W_Q = SQRT_W_Q;

    sqrt_stage_state_t state_q;
    sqrt_stage_state_t state_d;

    sqrt_result_t   res_q;
    logic           accept;
    logic           out_hs;
    logic           mul_done;
    logic [W_D-1:0] prod;

    logic [W_D:0]   sum_ext;
    logic           err_c;
    logic [W_Q:0]   round_c;

    logic [W_Q:0]       q_round_q;
    logic [W_Q-1:0]     q_pass_q;
    logic               err_q;
    logic [W_CNT-1:0]   res_count_q;
    logic [W_CNT-1:0]   err_count_q;

    assign accept = (state_q == IDLE) && io.in_valid;
    assign out_hs = (state_q == OUT) && io.out_ready;

    sqrt_shift_add_mul u_mul (
        .clk   (clk),
        .rst_n (rst_n),
        .start (accept),
        .a     (io.in_q),
        .b     (io.in_q),
        .done  (mul_done),
        .prod  (prod)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (io.in_valid) state_d = MUL;
            MUL:     if (mul_done) state_d = CHECK;
            CHECK:   state_d = OUT;
            OUT:     if (io.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Capture the upstream result only on the accept edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q <= '0;
        end else if (accept) begin
            res_q <= '{d: io.in_d, q: io.in_q, r: io.in_r};
        end
    end

    // Consistency check in 33 bits so Q*Q + R cannot wrap into a match.
    always_comb begin
        sum_ext = {1'b0, prod} + (W_D + 1)'(res_q.r);
        err_c   = (sum_ext != {1'b0, res_q.d})
               || (res_q.r > {res_q.q, 1'b0});
        round_c = sqrt_round(res_q.q, res_q.r);
    end

    // Register check and rounding results; held through OUT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_round_q <= '0;
            q_pass_q  <= '0;
            err_q     <= 1'b0;
        end else if (state_q == CHECK) begin
            q_round_q <= round_c;
            q_pass_q  <= res_q.q;
            err_q     <= err_c;
        end
    end

    // Debug counters: results wrap, errors saturate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_count_q <= '0;
            err_count_q <= '0;
        end else if (out_hs) begin
            res_count_q <= res_count_q + W_CNT'(1);
            if (err_q && (err_count_q != '1)) begin
                err_count_q <= err_count_q + W_CNT'(1);
            end
        end
    end

    assign io.in_ready    = (state_q == IDLE);
    assign io.out_valid   = (state_q == OUT);
    assign io.out_q_round = q_round_q;
    assign io.out_q       = q_pass_q;
    assign io.out_err     = err_q;
    assign io.res_count   = res_count_q;
    assign io.err_count   = err_count_q;

endmodule

// File: tb/tb_sqrt_result_stage.sv
// Scoreboard bench for sqrt_result_stage.
// Expectations are queued at send time and popped on output.
module tb_sqrt_result_stage;
    import sqrt_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    sqrt_result_stage_if #(.W_CNT(16)) sif ();

    sqrt_result_stage #(.W_CNT(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (sif.slave)
    );

    typedef struct {
        logic [16:0] qr;
        logic [15:0] q;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int failures = 0;
    int exp_res = 0;
    int exp_err = 0;

    task automatic send(input logic [31:0] d, input logic [15:0] q,
                        input logic [16:0] r, input logic [16:0] qr_e,
                        input logic err_e);
        int n;
        exp_t e;
        n = 0;
        while (sif.in_ready !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (n >= 50) begin
            failures++;
            $display("FAIL send_ready: in_ready=%b required 1", sif.in_ready);
        end
        sif.in_valid = 1'b1;
        sif.in_d = d;
        sif.in_q = q;
        sif.in_r = r;
        e.qr = qr_e;
        e.q = q;
        e.err = err_e;
        sb.push_back(e);
        @(posedge clk); #1;
        sif.in_valid = 1'b0;
        sif.in_d = $urandom;
        sif.in_q = 16'($urandom);
        sif.in_r = 17'($urandom);
    endtask

    task automatic collect(output int lat, output exp_t obs);
        lat = 0;
        while (sif.out_valid !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        obs.qr = sif.out_q_round;
        obs.q = sif.out_q;
        obs.err = sif.out_err;
        sif.out_ready = 1'b1;
        @(posedge clk); #1;
        sif.out_ready = 1'b0;
        if (lat < 40) begin
            exp_res = (exp_res + 1) & 16'hFFFF;
            if (obs.err === 1'b1 && exp_err != 16'hFFFF) exp_err++;
        end
    endtask

    task automatic test_reset();
        checks++;
        if (sif.in_ready !== 1'b1 || sif.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_hs: in_ready=%b out_valid=%b required 1 0",
                     sif.in_ready, sif.out_valid);
        end
        checks++;
        if (sif.out_q_round !== 17'd0 || sif.out_q !== 16'd0
            || sif.out_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_out: qr=%0d q=%0d err=%b required 0 0 0",
                     sif.out_q_round, sif.out_q, sif.out_err);
        end
        checks++;
        if (sif.res_count !== 16'd0 || sif.err_count !== 16'd0) begin
            failures++;
            $display("FAIL reset_cnt: res=%0d err=%0d required 0 0",
                     sif.res_count, sif.err_count);
        end
    endtask

    task automatic run_vector(input string name, input logic [31:0] d,
                              input logic [15:0] q, input logic [16:0] r,
                              input logic [16:0] qr_e, input logic err_e);
        int lat;
        exp_t obs;
        exp_t e;
        send(d, q, r, qr_e, err_e);
        collect(lat, obs);
        e = sb.pop_front();
        checks++;
        if (lat !== 17) begin
            failures++;
            $display("FAIL %s_lat: got %0d required 17", name, lat);
        end
        checks++;
        if (obs.qr !== e.qr || obs.q !== e.q) begin
            failures++;
            $display("FAIL %s_q: qr=%0d q=%0d required %0d %0d",
                     name, obs.qr, obs.q, e.qr, e.q);
        end
        checks++;
        if (obs.err !== e.err) begin
            failures++;
            $display("FAIL %s_err: got %b required %b", name, obs.err, e.err);
        end
        checks++;
        if (sif.res_count !== 16'(exp_res) || sif.err_count !== 16'(exp_err)) begin
            failures++;
            $display("FAIL %s_cnt: res=%0d err=%0d required %0d %0d",
                     name, sif.res_count, sif.err_count, exp_res, exp_err);
        end
    endtask

    task automatic test_rounding();
        run_vector("zero", 32'd0, 16'd0, 17'd0, 17'd0, 1'b0);
        run_vector("d15", 32'd15, 16'd3, 17'd6, 17'd4, 1'b0);
        run_vector("d100", 32'd100, 16'd10, 17'd0, 17'd10, 1'b0);
    endtask

    task automatic test_overflow();
        run_vector("max", 32'hFFFF_FFFF, 16'hFFFF, 17'd131070, 17'd65536, 1'b0);
        run_vector("ovf", 32'hFFFF_FFFF, 16'hFFFF, 17'd131069, 17'd65536, 1'b1);
    endtask

    task automatic test_error();
        run_vector("r_gt_2q", 32'd16, 16'd3, 17'd7, 17'd4, 1'b1);
        run_vector("sum_bad", 32'd16, 16'd4, 17'd1, 17'd4, 1'b1);
    endtask

    task automatic test_backpressure();
        int n;
        exp_t snap;
        exp_t e;
        logic stable;
        send(32'd15, 16'd3, 17'd6, 17'd4, 1'b0);
        n = 0;
        while (sif.out_valid !== 1'b1 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        snap.qr = sif.out_q_round;
        snap.q = sif.out_q;
        snap.err = sif.out_err;
        stable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            sif.in_valid = 1'b1;
            sif.in_d = 32'd100;
            sif.in_q = 16'd10;
            sif.in_r = 17'd0;
            @(posedge clk); #1;
            if (sif.out_valid !== 1'b1 || sif.in_ready !== 1'b0
                || sif.out_q_round !== snap.qr || sif.out_q !== snap.q
                || sif.out_err !== snap.err) stable = 1'b0;
        end
        sif.in_valid = 1'b0;
        checks++;
        if (stable !== 1'b1) begin
            failures++;
            $display("FAIL bp_stable: outputs or in_ready moved, got %b required 1",
                     stable);
        end
        e = sb.pop_front();
        checks++;
        if (snap.qr !== e.qr || snap.err !== e.err) begin
            failures++;
            $display("FAIL bp_value: qr=%0d err=%b required %0d %b",
                     snap.qr, snap.err, e.qr, e.err);
        end
        sif.out_ready = 1'b1;
        @(posedge clk); #1;
        sif.out_ready = 1'b0;
        exp_res++;
        checks++;
        if (sif.in_ready !== 1'b1 || sif.out_valid !== 1'b0
            || sif.res_count !== 16'(exp_res)) begin
            failures++;
            $display("FAIL bp_hs: in_ready=%b out_valid=%b res=%0d required 1 0 %0d",
                     sif.in_ready, sif.out_valid, sif.res_count, exp_res);
        end
        repeat (20) @(posedge clk);
        #1;
        checks++;
        if (sif.out_valid !== 1'b0 || sif.res_count !== 16'(exp_res)) begin
            failures++;
            $display("FAIL bp_second: out_valid=%b res=%0d required 0 %0d",
                     sif.out_valid, sif.res_count, exp_res);
        end
    endtask

    task automatic test_reset_mid_mul();
        send(32'd100, 16'd10, 17'd0, 17'd10, 1'b0);
        repeat (8) @(posedge clk);
        #1;
        rst_n = 1'b0;
        void'(sb.pop_back());
        exp_res = 0;
        exp_err = 0;
        #1;
        checks++;
        if (sif.out_valid !== 1'b0 || sif.in_ready !== 1'b1
            || sif.res_count !== 16'd0 || sif.err_count !== 16'd0) begin
            failures++;
            $display("FAIL mid_rst: ov=%b ir=%b res=%0d err=%0d required 0 1 0 0",
                     sif.out_valid, sif.in_ready, sif.res_count, sif.err_count);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_vector("after_rst", 32'd16, 16'd4, 17'd1, 17'd4, 1'b1);
    endtask

    task automatic test_back_to_back();
        logic [15:0] q;
        logic [16:0] r;
        logic [31:0] d;
        logic [16:0] qr;
        logic bad;
        for (int i = 0; i < 6; i++) begin
            q = 16'($urandom);
            r = 17'($urandom_range(0, 2 * int'(q)));
            d = 32'(q) * 32'(q) + 32'(r);
            bad = (i % 3 == 2);
            if (bad) d = d ^ (32'd1 << $urandom_range(0, 31));
            qr = (r > 17'(q)) ? 17'(q) + 17'd1 : 17'(q);
            run_vector("b2b", d, q, r, qr, bad);
        end
    endtask

    initial begin
        sif.in_valid = 1'b0;
        sif.in_d = '0;
        sif.in_q = '0;
        sif.in_r = '0;
        sif.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        rst_n = 1'b1;
        @(posedge clk); #1;
        test_rounding();
        test_overflow();
        test_error();
        test_backpressure();
        test_reset_mid_mul();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sqrt_result_stage.md
# sqrt_result_stage

Sequential post-processing stage placed directly downstream of the combinational `non_restoring_sqrt` block. It captures one {D, Q, R} result, checks it with an iterative 16-cycle shift-add multiplier (Q·Q + R == D and R ≤ 2Q), and rounds Q to the nearest integer. It returns the rounded root with an error flag over a valid/ready handshake, and keeps running result and error counts for debug.

## Interface
- `W_D`, 32: radicand width.
- `W_Q`, 16: root width (`W_D/2`).
- `W_R`, 17: remainder width (`W_Q+1`).
- `W_CNT`, 16: width of the statistics counters.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  upstream {D, Q, R} valid.
- `in_ready`  out  1  stage can accept; high only in IDLE.
- `in_d`  in  W_D  radicand fed to the sqrt block.
- `in_q`  in  W_Q  root from the sqrt block.
- `in_r`  in  W_R  remainder from the sqrt block.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  downstream accepts.
- `out_q_round`  out  W_Q+1  root rounded to nearest; 17 bits, so 65535 can round up to 65536.
- `out_q`  out  W_Q  unrounded root, passed through.
- `out_err`  out  1  consistency check failed.
- `res_count`  out  W_CNT  results delivered; wraps.
- `err_count`  out  W_CNT  results delivered with `out_err`=1; saturates at all-ones.

## Operation
- FSM states:
  - IDLE → MUL on `in_valid && in_ready`. Capture D, Q, R; clear the 32-bit accumulator; `cnt` = 0.
  - MUL: each cycle, if `q_cap[cnt]` is set, add `q_cap << cnt` to the accumulator; `cnt++`. After the edge where `cnt` = 15 is processed, go to CHECK.
  - CHECK: one cycle. Compute the error condition and the rounded root, register both, go to OUT.
  - OUT: hold all outputs stable until `out_ready`. On the handshake edge, go to IDLE, increment `res_count`, and increment `err_count` if `out_err`.
- Error condition: `out_err` = ({1'b0, acc} + R ≠ {1'b0, D}) || (R > {Q, 1'b0}).
  - The sum is done in 33 bits. Overflow beyond 32 bits is a mismatch, never a wrap.
- Rounding: `out_q_round` = Q + 1 when R > Q, else Q, computed in 17 bits.
  - This follows from (Q+0.5)² = Q² + Q + 0.25.
  - Rounding is applied even when `out_err`=1.
- Inputs are sampled only on the accept edge. Changes to `in_*` after that edge are ignored.
- `in_ready` = (state == IDLE). There is no same-cycle turnaround from OUT to accept.

## Timing
- Reset values: state IDLE, `in_ready`=1 after reset, `out_valid`=0, `out_q_round`=0, `out_q`=0, `out_err`=0, `res_count`=0, `err_count`=0, accumulator and `cnt` = 0.
- Latency: accept on edge k; MUL covers edges k+1..k+16; CHECK result is registered on edge k+17; `out_valid` is high from edge k+17.
- Minimum initiation interval: 19 cycles (accept, 16 MUL, CHECK, and at least one OUT cycle with `out_ready`=1).
- Backpressure: while `out_valid && !out_ready`, all `out_*` remain bit-stable for any number of cycles.
- Reset asserted mid-MUL, mid-CHECK or mid-OUT: immediate return to the reset values. The in-flight result is dropped and not counted.
- `err_count` at all-ones: stays there. `res_count` at all-ones: wraps to 0.

## Structure
- Shared package `sqrt_pkg`:
  - width constants (`SQRT_W_D`, `SQRT_W_Q`, `SQRT_W_R`);
  - state enum `sqrt_stage_state_t` {IDLE, MUL, CHECK, OUT};
  - the {D, Q, R} result struct, shared with the sqrt block wrapper.
- One sub-module, `sqrt_shift_add_mul`: a 16×16 iterative multiplier with start/done, one bit per cycle, 32-bit product.
- The FSM, checker, rounder and counters stay in the top module.

## Test plan
- D=0, Q=0, R=0 → after 17 cycles `out_q_round`=0, `out_err`=0, `res_count`=1.
- D=15, Q=3, R=6 → `out_q_round`=4, `out_err`=0. D=100, Q=10, R=0 → `out_q_round`=10, `out_err`=0.
- D=4294967295, Q=65535, R=131070 → `out_q_round`=65536, `out_err`=0 (no 33-bit overflow mismatch).
- D=16, Q=3, R=7 (sum matches, R > 2Q) → `out_err`=1, `err_count`=1. D=16, Q=4, R=1 → `out_err`=1.
- Backpressure: hold `out_ready`=0 for 5 cycles after `out_valid`.
  - Required: outputs stable, `in_ready`=0, a second `in_valid` is not accepted.
  - Required: single handshake then `res_count` +1, and `in_ready`=1 the next cycle.
- Assert `rst_n`=0 on cycle 8 of MUL → `out_valid`=0 and counters=0 immediately. A fresh request then completes with the normal 17-cycle latency.
